// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch controller slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

    localparam int unsigned DEFAULT_PRESCALE = 100_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE = 1_000_000;

    function automatic logic is_counting(input sw_state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// One front-panel button: 2-FF synchronizer, stable-level counter, one-cycle press pulse on accepted rise.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt tracks how long the synchronized input has disagreed with the accepted level
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/pause/lap/clear sequencer and count-tick prescaler for the 00-59 seconds counter.
// Optional auto-stop at 59 is compiled in with `define STOPWATCH_AUTOSTOP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_clr,
    input  logic       cnt_tc,
    output logic       tick,
    output logic       clr,
    output logic       hold,
    output logic       running,
    output logic [1:0] state,
    output logic       done
);

    localparam int unsigned   PW       = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic          ss_p;
    logic          lap_p;
    logic          clr_p;
    sw_state_t     state_q;
    sw_state_t     state_n;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_n;
    logic          tick_n;
    logic          clr_n;
    logic          wrap;
    logic          auto_stop;

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_ss (
        .CLK  (CLK),
        .RST  (RST),
        .btn  (btn_ss),
        .press(ss_p)
    );

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_lap (
        .CLK  (CLK),
        .RST  (RST),
        .btn  (btn_lap),
        .press(lap_p)
    );

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_clr (
        .CLK  (CLK),
        .RST  (RST),
        .btn  (btn_clr),
        .press(clr_p)
    );

    assign wrap = (pre_q == PRE_LAST);

`ifdef STOPWATCH_AUTOSTOP_EN
    // Set by an auto-stop so the first wrap after resuming ticks the counter through 59->00.
    logic tc_bypass;

    assign auto_stop = wrap && cnt_tc && !tc_bypass;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tc_bypass <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= !clr_p && is_counting(state_q) && auto_stop;
            if (clr_p) begin
                tc_bypass <= 1'b0;
            end else if (is_counting(state_q) && wrap) begin
                tc_bypass <= auto_stop;
            end
        end
    end
`else
    logic unused_cnt_tc;

    assign unused_cnt_tc = cnt_tc;
    assign auto_stop     = 1'b0;
    assign done          = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        pre_n   = pre_q;
        tick_n  = 1'b0;
        clr_n   = 1'b0;
        if (clr_p) begin
            state_n = ST_IDLE;
            pre_n   = '0;
            clr_n   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ss_p) begin
                        state_n = ST_RUN;
                        pre_n   = '0;
                    end
                end
                ST_RUN, ST_LAP: begin
                    pre_n = wrap ? '0 : pre_q + 1'b1;
                    if (auto_stop) begin
                        state_n = ST_PAUSE;
                    end else begin
                        tick_n = wrap;
                        if (ss_p) begin
                            state_n = ST_PAUSE;
                        end else if (lap_p) begin
                            state_n = (state_q == ST_RUN) ? ST_LAP : ST_RUN;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (ss_p) begin
                        state_n = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            tick    <= 1'b0;
            clr     <= 1'b0;
            hold    <= 1'b0;
            running <= 1'b0;
        end else begin
            state_q <= state_n;
            pre_q   <= pre_n;
            tick    <= tick_n;
            clr     <= clr_n;
            hold    <= (state_n == ST_LAP);
            running <= is_counting(state_n);
        end
    end

    assign state = state_q;

endmodule
